btb_bimodal_predictor: RTL and testbench

BTB_BIMODAL_PREDICTOR -- requirements
Module: btb_bimodal_predictor

---
 rtl/btb_bimodal_predictor.sv | 118 +++++++++++
 tb/tb_btb_bimodal_predictor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_bimodal_predictor.sv
// Direct-mapped branch target buffer with 2-bit bimodal counters and combinational fetch lookup.
// Optional build macro BTB_STATS_EN adds saturating update/mispredict statistic counters.
module btb_bimodal_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        we_i,
    input  logic [31:0] pcE_i,
    input  logic [31:0] dirsaltoE_i,
    input  logic        branch_taken_i,
    input  logic [1:0]  old_prediction_i,
    input  logic        desactivar_bp_i,
    input  logic [31:0] pcF_i,
    output logic [31:0] dirobjetivoF_o,
    output logic [1:0]  prediccion_o,
    output logic        sel_mux_pred_o,
`ifdef BTB_STATS_EN
    output logic        hit_o,
    output logic [15:0] stat_updates_o,
    output logic [15:0] stat_mispred_o
`else
    output logic        hit_o
`endif
);

    localparam int unsigned IDXW = $clog2(ENTRIES);
    localparam int unsigned TAGW = 30 - IDXW;
    localparam logic [1:0]  CTR_WEAK_NT = 2'b01;
    localparam logic [1:0]  CTR_WEAK_T  = 2'b10;

    logic              valid_q  [ENTRIES];
    logic [TAGW-1:0]   tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [IDXW-1:0]   idx_f;
    logic [TAGW-1:0]   tag_f;
    logic [IDXW-1:0]   idx_e;
    logic [TAGW-1:0]   tag_e;
    logic              hit_e;
    logic [1:0]        ctr_e;
    logic [1:0]        ctr_next;

    assign idx_f = pcF_i[IDXW+1:2];
    assign tag_f = pcF_i[31:IDXW+2];
    assign idx_e = pcE_i[IDXW+1:2];
    assign tag_e = pcE_i[31:IDXW+2];

    // Fetch lookup reads the registered table, so a same-cycle update is seen one cycle later
    always_comb begin
        hit_o          = 1'b0;
        prediccion_o   = CTR_WEAK_NT;
        dirobjetivoF_o = 32'h0;
        sel_mux_pred_o = 1'b0;
        if (valid_q[idx_f] && (tag_q[idx_f] == tag_f) && !desactivar_bp_i) begin
            hit_o          = 1'b1;
            prediccion_o   = ctr_q[idx_f];
            dirobjetivoF_o = target_q[idx_f];
            sel_mux_pred_o = ctr_q[idx_f][1];
        end
    end

    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign ctr_e = ctr_q[idx_e];

    // Saturating counter step for the resolving entry
    always_comb begin
        ctr_next = ctr_e;
        if (branch_taken_i) begin
            if (ctr_e != 2'b11) ctr_next = ctr_e + 2'd1;
        end else begin
            if (ctr_e != 2'b00) ctr_next = ctr_e - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
        end else if (we_i) begin
            if (hit_e) begin
                ctr_q[idx_e] <= ctr_next;
                if (branch_taken_i) target_q[idx_e] <= dirsaltoE_i;
            end else begin
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= dirsaltoE_i;
                ctr_q[idx_e]    <= branch_taken_i ? CTR_WEAK_T : CTR_WEAK_NT;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic unused_bits;
    assign unused_bits = ^{pcE_i[1:0], pcF_i[1:0], old_prediction_i[0]};

    // Saturating statistics; mispredict compares the fetched direction with the resolved one
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stat_updates_o <= 16'h0;
            stat_mispred_o <= 16'h0;
        end else if (we_i) begin
            if (stat_updates_o != 16'hFFFF) stat_updates_o <= stat_updates_o + 16'd1;
            if ((old_prediction_i[1] != branch_taken_i) && (stat_mispred_o != 16'hFFFF))
                stat_mispred_o <= stat_mispred_o + 16'd1;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{pcE_i[1:0], pcF_i[1:0], old_prediction_i};
`endif

endmodule

// File: tb/tb_btb_bimodal_predictor.sv
// Self-checking bench for btb_bimodal_predictor: directed scenarios plus random traffic
// against a table-level reference model (define BTB_STATS_EN to also cover statistics).
module tb_btb_bimodal_predictor;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        we_i;
    logic [31:0] pcE_i;
    logic [31:0] dirsaltoE_i;
    logic        branch_taken_i;
    logic [1:0]  old_prediction_i;
    logic        desactivar_bp_i;
    logic [31:0] pcF_i;
    logic [31:0] dirobjetivoF_o;
    logic [1:0]  prediccion_o;
    logic        sel_mux_pred_o;
    logic        hit_o;
`ifdef BTB_STATS_EN
    logic [15:0] stat_updates_o;
    logic [15:0] stat_mispred_o;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: 16 entries, index = (pc/4) mod 16, tag = pc/64
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    int          m_ctr   [16];
    int          m_upd;
    int          m_mis;

    btb_bimodal_predictor #(.ENTRIES(16)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .we_i             (we_i),
        .pcE_i            (pcE_i),
        .dirsaltoE_i      (dirsaltoE_i),
        .branch_taken_i   (branch_taken_i),
        .old_prediction_i (old_prediction_i),
        .desactivar_bp_i  (desactivar_bp_i),
        .pcF_i            (pcF_i),
        .dirobjetivoF_o   (dirobjetivoF_o),
        .prediccion_o     (prediccion_o),
        .sel_mux_pred_o   (sel_mux_pred_o),
`ifdef BTB_STATS_EN
        .hit_o            (hit_o),
        .stat_updates_o   (stat_updates_o),
        .stat_mispred_o   (stat_mispred_o)
`else
        .hit_o            (hit_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt,
                             input logic taken, input logic [1:0] oldp);
        we_i = 1'b1; pcE_i = pc; dirsaltoE_i = tgt;
        branch_taken_i = taken; old_prediction_i = oldp;
        tick();
        we_i = 1'b0;
    endtask

    task automatic apply_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_upd = 0; m_mis = 0;
    endtask

    task automatic model_update(input int unsigned pc, input int unsigned tgt,
                                input bit taken, input int oldp);
        int idx;
        int unsigned tg;
        idx = int'((pc >> 2) % 16);
        tg  = pc >> 6;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            m_ctr[idx] = taken ? ((m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1)
                               : ((m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1);
            if (taken) m_tgt[idx] = tgt;
        end else begin
            m_valid[idx] = 1'b1; m_tag[idx] = tg; m_tgt[idx] = tgt;
            m_ctr[idx] = taken ? 2 : 1;
        end
        if (m_upd < 65535) m_upd++;
        if (((oldp / 2) != int'(taken)) && m_mis < 65535) m_mis++;
    endtask

    task automatic test_reset();
        we_i = 1'b0; desactivar_bp_i = 1'b0; pcF_i = 32'h40;
        apply_reset();
        vectors++; if (hit_o !== 1'b0) begin miscompares++; $display("FAIL reset_hit got %b want 0", hit_o); end
        vectors++; if (sel_mux_pred_o !== 1'b0) begin miscompares++; $display("FAIL reset_sel got %b want 0", sel_mux_pred_o); end
        vectors++; if (prediccion_o !== 2'b01) begin miscompares++; $display("FAIL reset_pred got %b want 01", prediccion_o); end
        vectors++; if (dirobjetivoF_o !== 32'h0) begin miscompares++; $display("FAIL reset_target got %h want 0", dirobjetivoF_o); end
    endtask

    task automatic test_allocate_saturate();
        do_update(32'h40, 32'h100, 1'b1, 2'b01);
        pcF_i = 32'h40; #1;
        vectors++; if (hit_o !== 1'b1) begin miscompares++; $display("FAIL alloc_hit got %b want 1", hit_o); end
        vectors++; if (prediccion_o !== 2'b10) begin miscompares++; $display("FAIL alloc_pred got %b want 10", prediccion_o); end
        vectors++; if (dirobjetivoF_o !== 32'h100) begin miscompares++; $display("FAIL alloc_target got %h want 100", dirobjetivoF_o); end
        vectors++; if (sel_mux_pred_o !== 1'b1) begin miscompares++; $display("FAIL alloc_sel got %b want 1", sel_mux_pred_o); end
        for (int i = 0; i < 3; i++) do_update(32'h40, 32'h100, 1'b1, 2'b10);
        vectors++; if (prediccion_o !== 2'b11) begin miscompares++; $display("FAIL sat_up_pred got %b want 11", prediccion_o); end
        for (int i = 0; i < 4; i++) do_update(32'h40, 32'hDEAD_0000, 1'b0, 2'b11);
        vectors++; if (prediccion_o !== 2'b00) begin miscompares++; $display("FAIL sat_dn_pred got %b want 00", prediccion_o); end
        vectors++; if (sel_mux_pred_o !== 1'b0) begin miscompares++; $display("FAIL sat_dn_sel got %b want 0", sel_mux_pred_o); end
        vectors++; if (dirobjetivoF_o !== 32'h100) begin miscompares++; $display("FAIL sat_dn_target got %h want 100", dirobjetivoF_o); end
    endtask

    task automatic test_alias();
        pcF_i = 32'h80; #1;
        vectors++; if (hit_o !== 1'b0) begin miscompares++; $display("FAIL alias_lookup_hit got %b want 0", hit_o); end
        do_update(32'h80, 32'h200, 1'b1, 2'b01);
        pcF_i = 32'h40; #1;
        vectors++; if (hit_o !== 1'b0) begin miscompares++; $display("FAIL alias_old_hit got %b want 0", hit_o); end
        pcF_i = 32'h83; #1;
        vectors++; if (hit_o !== 1'b1 || dirobjetivoF_o !== 32'h200) begin
            miscompares++; $display("FAIL alias_new got hit=%b tgt=%h want hit=1 tgt=200", hit_o, dirobjetivoF_o); end
    endtask

    task automatic test_back_to_back();
        do_update(32'h40, 32'h100, 1'b0, 2'b01);
        we_i = 1'b1; pcE_i = 32'h40; dirsaltoE_i = 32'h300; branch_taken_i = 1'b1;
        old_prediction_i = 2'b01; pcF_i = 32'h40; #1;
        vectors++; if (prediccion_o !== 2'b01 || hit_o !== 1'b1) begin
            miscompares++; $display("FAIL same_cycle got pred=%b hit=%b want 01/1", prediccion_o, hit_o); end
        tick();
        we_i = 1'b0;
        vectors++; if (prediccion_o !== 2'b10 || dirobjetivoF_o !== 32'h300 || sel_mux_pred_o !== 1'b1) begin
            miscompares++; $display("FAIL next_cycle got pred=%b tgt=%h sel=%b want 10/300/1",
                                    prediccion_o, dirobjetivoF_o, sel_mux_pred_o); end
        desactivar_bp_i = 1'b1; #1;
        vectors++; if (sel_mux_pred_o !== 1'b0 || hit_o !== 1'b0) begin
            miscompares++; $display("FAIL disable got sel=%b hit=%b want 0/0", sel_mux_pred_o, hit_o); end
        do_update(32'h40, 32'h340, 1'b1, 2'b10);
        desactivar_bp_i = 1'b0; #1;
        vectors++; if (prediccion_o !== 2'b11 || dirobjetivoF_o !== 32'h340) begin
            miscompares++; $display("FAIL update_while_disabled got pred=%b tgt=%h want 11/340", prediccion_o, dirobjetivoF_o); end
    endtask

    task automatic test_reset_mid_update();
        we_i = 1'b1; pcE_i = 32'h44; dirsaltoE_i = 32'h500; branch_taken_i = 1'b1;
        old_prediction_i = 2'b01;
        #2 reset_i = 1'b1;
        tick();
        we_i = 1'b0; reset_i = 1'b0;
        pcF_i = 32'h44; #1;
        vectors++; if (hit_o !== 1'b0) begin miscompares++; $display("FAIL reset_mid_update hit got %b want 0", hit_o); end
        pcF_i = 32'h40; #1;
        vectors++; if (hit_o !== 1'b0 || prediccion_o !== 2'b01) begin
            miscompares++; $display("FAIL reset_clears_table got hit=%b pred=%b want 0/01", hit_o, prediccion_o); end
    endtask

`ifdef BTB_STATS_EN
    task automatic test_stats();
        apply_reset();
        do_update(32'h40, 32'h100, 1'b1, 2'b01);
        do_update(32'h40, 32'h100, 1'b1, 2'b10);
        do_update(32'h40, 32'h100, 1'b0, 2'b11);
        vectors++; if (stat_updates_o !== 16'd3) begin miscompares++; $display("FAIL stat_updates got %0d want 3", stat_updates_o); end
        vectors++; if (stat_mispred_o !== 16'd2) begin miscompares++; $display("FAIL stat_mispred got %0d want 2", stat_mispred_o); end
    endtask
`endif

    function automatic logic [31:0] rand_pc();
        int unsigned tg;
        tg = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 3);
        return (tg << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    endfunction

    task automatic test_random();
        int idx;
        int unsigned tg;
        logic        e_hit;
        logic [1:0]  e_pred;
        logic [31:0] e_tgt;
        logic        e_sel;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            we_i             = ($urandom_range(0, 2) != 0);
            pcE_i            = rand_pc();
            dirsaltoE_i      = $urandom;
            branch_taken_i   = 1'($urandom_range(0, 1));
            old_prediction_i = 2'($urandom_range(0, 3));
            desactivar_bp_i  = ($urandom_range(0, 7) == 0);
            pcF_i            = ($urandom_range(0, 3) == 0) ? pcE_i : rand_pc();
            #3;
            idx = int'((pcF_i >> 2) % 16);
            tg  = pcF_i >> 6;
            e_hit  = m_valid[idx] && (m_tag[idx] == tg) && !desactivar_bp_i;
            e_pred = e_hit ? 2'(m_ctr[idx]) : 2'b01;
            e_tgt  = e_hit ? m_tgt[idx] : 32'h0;
            e_sel  = e_hit && (m_ctr[idx] >= 2);
            vectors++; if (hit_o !== e_hit || prediccion_o !== e_pred) begin
                miscompares++; $display("FAIL rand_lookup[%0d] pc=%h got hit=%b pred=%b want hit=%b pred=%b",
                                        n, pcF_i, hit_o, prediccion_o, e_hit, e_pred); end
            vectors++; if (dirobjetivoF_o !== e_tgt || sel_mux_pred_o !== e_sel) begin
                miscompares++; $display("FAIL rand_target[%0d] pc=%h got tgt=%h sel=%b want tgt=%h sel=%b",
                                        n, pcF_i, dirobjetivoF_o, sel_mux_pred_o, e_tgt, e_sel); end
`ifdef BTB_STATS_EN
            vectors++; if (stat_updates_o !== 16'(m_upd) || stat_mispred_o !== 16'(m_mis)) begin
                miscompares++; $display("FAIL rand_stats[%0d] got %0d/%0d want %0d/%0d",
                                        n, stat_updates_o, stat_mispred_o, m_upd, m_mis); end
`endif
            @(posedge clk_i);
            if (we_i) model_update(pcE_i, dirsaltoE_i, branch_taken_i, int'(old_prediction_i));
            #1;
        end
        we_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; we_i = 1'b0; pcE_i = 32'h0; dirsaltoE_i = 32'h0;
        branch_taken_i = 1'b0; old_prediction_i = 2'b01; desactivar_bp_i = 1'b0; pcF_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        test_allocate_saturate();
        test_alias();
        test_back_to_back();
        test_reset_mid_update();
`ifdef BTB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
